// File: rtl/uart_rx_sipo.sv
// uart_rx_sipo: oversampling UART receiver (serial in, parallel out).
// Finds the start bit and samples each bit near its centre. Data bits are
// shifted in LSB-first, and a one-cycle valid or framing-error strobe is
// raised once the stop bit has been checked.
module uart_rx_sipo #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 slow_baud_clk,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 framing_error,
  output logic                 rx_busy
);

  localparam int CntW = $clog2(OVERSAMPLE);
  localparam int BitW = $clog2(DATA_BITS + 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0] LastBit  = BitW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    Idle,
    Start,
    Data,
    Stop,
    Recover
  } state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BitW-1:0]      bitIdx_q, bitIdx_d;
  logic [DATA_BITS-1:0] shiftReg_q, shiftReg_d;
  logic [DATA_BITS-1:0] rxData_q, rxData_d;
  logic                 rxValid_q, rxValid_d;
  logic                 frameErr_q, frameErr_d;
  logic                 rxBusy_q, rxBusy_d;
  logic                 rxMeta_q, rxSync_q;
  logic [DATA_BITS:0]   shiftIn;

  // Two-flop synchronizer; resets to the idle-high line level so that a
  // reset never looks like a falling edge.
  always_ff @(posedge slow_baud_clk) begin
    if (reset) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= rx_in;
      rxSync_q <= rxMeta_q;
    end
  end

  // Next-state logic: counters, shift register and the output strobes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitIdx_d   = bitIdx_q;
    shiftReg_d = shiftReg_q;
    rxData_d   = rxData_q;
    rxValid_d  = 1'b0;
    frameErr_d = 1'b0;
    shiftIn    = {rxSync_q, shiftReg_q};
    unique case (state_q)
      Idle: begin
        if (!rxSync_q) begin
          state_d = Start;
          cnt_d   = '0;
        end
      end
      Start: begin
        if (cnt_q != HalfLast) begin
          cnt_d = cnt_q + 1'b1;
        end else if (!rxSync_q) begin
          state_d  = Data;
          cnt_d    = '0;
          bitIdx_d = '0;
        end else begin
          state_d = Idle;
        end
      end
      Data: begin
        if (cnt_q != FullLast) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          shiftReg_d = shiftIn[DATA_BITS:1];
          bitIdx_d   = bitIdx_q + 1'b1;
          cnt_d      = '0;
          if (bitIdx_q == LastBit) begin
            state_d = Stop;
          end
        end
      end
      Stop: begin
        if (cnt_q != FullLast) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (rxSync_q) begin
            rxData_d  = shiftReg_q;
            rxValid_d = 1'b1;
            state_d   = Idle;
          end else begin
            frameErr_d = 1'b1;
            state_d    = Recover;
          end
        end
      end
      Recover: begin
        if (rxSync_q) begin
          state_d = Idle;
        end
      end
      default: begin
        state_d = Idle;
      end
    endcase
    rxBusy_d = (state_d != Idle);
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge slow_baud_clk) begin
    if (reset) begin
      state_q    <= Idle;
      cnt_q      <= '0;
      bitIdx_q   <= '0;
      shiftReg_q <= '0;
      rxData_q   <= '0;
      rxValid_q  <= 1'b0;
      frameErr_q <= 1'b0;
      rxBusy_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitIdx_q   <= bitIdx_d;
      shiftReg_q <= shiftReg_d;
      rxData_q   <= rxData_d;
      rxValid_q  <= rxValid_d;
      frameErr_q <= frameErr_d;
      rxBusy_q   <= rxBusy_d;
    end
  end

  assign rx_data       = rxData_q;
  assign rx_valid      = rxValid_q;
  assign framing_error = frameErr_q;
  assign rx_busy       = rxBusy_q;

endmodule
